// File: rtl/arp_requester_if.sv
// arp_requester_if: lookup request/result handshake plus the ARP tx and rx payload streams
interface arp_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_ip;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_ok;
    logic [31:0] resp_ip;
    logic [47:0] resp_mac;
    logic        axis_o_tready;
    logic        axis_o_tvalid;
    logic        axis_o_tlast;
    logic [3:0]  axis_o_tkeep;
    logic [31:0] axis_o_tdata;
    logic [47:0] axis_o_dst_mac;
    logic        axis_i_tready;
    logic        axis_i_tvalid;
    logic        axis_i_tlast;
    logic [3:0]  axis_i_tkeep;
    logic [31:0] axis_i_tdata;

    modport master (
        input  req_valid, req_ip, resp_ready, axis_o_tready,
        input  axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
        output req_ready, resp_valid, resp_ok, resp_ip, resp_mac,
        output axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata, axis_o_dst_mac,
        output axis_i_tready
    );

    modport slave (
        output req_valid, req_ip, resp_ready, axis_o_tready,
        output axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
        input  req_ready, resp_valid, resp_ok, resp_ip, resp_mac,
        input  axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata, axis_o_dst_mac,
        input  axis_i_tready
    );
endinterface

// File: rtl/arp_requester.sv
// arp_requester: broadcasts ARP requests with timeout/retry and parses incoming payloads for the matching reply
module arp_requester #(
    parameter int          AXIS_BYTES     = 4,
    parameter logic [47:0] OUR_MAC        = 48'h0,
    parameter logic [31:0] OUR_IP         = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          MAX_RETRIES    = 3
) (
    input logic           clk,
    input logic           sresetn,
    arp_requester_if.master bus
);
    localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

    state_t        state;
    logic [31:0]   ip;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic [2:0]    tx_beat;
    logic [2:0]    rx_beat;
    logic          hdr_ok;
    logic          oper_ok;
    logic [47:0]   sha;
    logic [31:0]   spa;
    logic          match;
    logic          timeout;
    logic          unused;

    function automatic logic [31:0] tx_word(input logic [2:0] i, input logic [31:0] tpa);
        return i == 3'd0 ? 32'h00080100 :
               i == 3'd1 ? 32'h01000406 :
               i == 3'd2 ? OUR_MAC[31:0] :
               i == 3'd3 ? {OUR_IP[15:0], OUR_MAC[47:32]} :
               i == 3'd4 ? {16'h0, OUR_IP[31:16]} :
               i == 3'd5 ? 32'h0 : tpa;
    endfunction

    assign bus.req_ready      = state == IDLE;
    assign bus.axis_o_tkeep   = {AXIS_BYTES{1'b1}};
    assign bus.axis_o_dst_mac = '1;
    assign bus.axis_i_tready  = 1'b1;
    assign unused             = ^bus.axis_i_tkeep;
    assign timeout            = timer == TW'(TIMEOUT_CYCLES - 1);
    assign match = bus.axis_i_tvalid && rx_beat == 3'd6 && state == WAIT && hdr_ok && oper_ok && spa == ip;

    // Header fields are captured beat by beat; every packet rewrites them before its beat 6
    always_ff @(posedge clk or negedge sresetn)
        if (!sresetn) begin
            rx_beat <= '0;
            hdr_ok  <= 1'b0;
            oper_ok <= 1'b0;
            sha     <= '0;
            spa     <= '0;
        end else if (bus.axis_i_tvalid) begin
            rx_beat <= bus.axis_i_tlast ? 3'd0 : rx_beat == 3'd7 ? 3'd7 : rx_beat + 3'd1;
            if (rx_beat == 3'd0) hdr_ok <= bus.axis_i_tdata == 32'h00080100;
            if (rx_beat == 3'd1) oper_ok <= bus.axis_i_tdata == 32'h02000406;
            if (rx_beat == 3'd2) sha[31:0] <= bus.axis_i_tdata;
            if (rx_beat == 3'd3) begin
                sha[47:32] <= bus.axis_i_tdata[15:0];
                spa[15:0]  <= bus.axis_i_tdata[31:16];
            end
            if (rx_beat == 3'd4) spa[31:16] <= bus.axis_i_tdata[15:0];
        end

    always_ff @(posedge clk or negedge sresetn)
        if (!sresetn) begin
            state             <= IDLE;
            ip                <= '0;
            timer             <= '0;
            retries           <= '0;
            tx_beat           <= '0;
            bus.axis_o_tvalid <= 1'b0;
            bus.axis_o_tlast  <= 1'b0;
            bus.axis_o_tdata  <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_ok       <= 1'b0;
            bus.resp_mac      <= '0;
            bus.resp_ip       <= '0;
        end else
            case (state)
                IDLE: if (bus.req_valid) begin
                    ip                <= bus.req_ip;
                    retries           <= RW'(MAX_RETRIES);
                    state             <= SEND;
                    tx_beat           <= '0;
                    bus.axis_o_tvalid <= 1'b1;
                    bus.axis_o_tlast  <= 1'b0;
                    bus.axis_o_tdata  <= 32'h00080100;
                end
                SEND: if (bus.axis_o_tready) begin
                    if (tx_beat == 3'd6) begin
                        bus.axis_o_tvalid <= 1'b0;
                        bus.axis_o_tlast  <= 1'b0;
                        timer             <= '0;
                        state             <= WAIT;
                    end else begin
                        tx_beat          <= tx_beat + 3'd1;
                        bus.axis_o_tdata <= tx_word(tx_beat + 3'd1, ip);
                        bus.axis_o_tlast <= tx_beat == 3'd5;
                    end
                end
                WAIT: begin
                    timer <= timeout ? timer : timer + 1'b1;
                    if (match) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_ok    <= 1'b1;
                        bus.resp_mac   <= sha;
                        bus.resp_ip    <= ip;
                    end else if (timeout && retries != '0) begin
                        retries           <= retries - 1'b1;
                        state             <= SEND;
                        tx_beat           <= '0;
                        bus.axis_o_tvalid <= 1'b1;
                        bus.axis_o_tlast  <= 1'b0;
                        bus.axis_o_tdata  <= 32'h00080100;
                    end else if (timeout) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_ok    <= 1'b0;
                        bus.resp_mac   <= '0;
                        bus.resp_ip    <= ip;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_arp_requester.sv
// tb_arp_requester: scoreboard bench for arp_requester covering resolve, retry timeout, filtering, backpressure, padding and reset
module tb_arp_requester;
    localparam logic [47:0] MAC    = 48'h665544332211;
    localparam logic [31:0] LIP    = 32'h0B0AA8C0;
    localparam int          TO     = 100;
    localparam logic [31:0] IP_A   = 32'h140AA8C0;
    localparam logic [31:0] IP_BAD = 32'h150AA8C0;
    localparam logic [31:0] IP_B   = 32'h1E0AA8C0;
    localparam logic [47:0] MAC_A  = 48'h0F0E0D0C0B0A;
    localparam logic [47:0] MAC_B  = 48'h5A4B3C2D1E0F;
    localparam logic [47:0] MAC_C  = 48'h112233445566;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    bit          rnd = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          last_cyc = 0;
    bit          gap_pending = 1'b0;
    bit          prev_tv = 1'b0;
    bit          prev_tr = 1'b0;
    bit          prev_rv = 1'b0;
    bit          prev_hs = 1'b0;
    logic [31:0] prev_td;
    logic [80:0] prev_resp;
    logic [36:0] tx_e;
    logic [80:0] resp_e;
    logic [36:0] tx_q[$];
    logic [80:0] resp_q[$];

    arp_requester_if bus();

    arp_requester #(
        .AXIS_BYTES(4), .OUR_MAC(MAC), .OUR_IP(LIP), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .sresetn(sresetn), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 bus.axis_o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] tx_exp(input int i, input logic [31:0] ip);
        logic [31:0] d;
        case (i)
            0: d = 32'h00080100;
            1: d = 32'h01000406;
            2: d = MAC[31:0];
            3: d = {LIP[15:0], MAC[47:32]};
            4: d = {16'h0, LIP[31:16]};
            5: d = 32'h0;
            default: d = ip;
        endcase
        return {i == 6, 4'hF, d};
    endfunction

    function automatic logic [31:0] rx_word(input int i, input logic [7:0] oper, input logic [47:0] sha, input logic [31:0] spa);
        case (i)
            0: return 32'h00080100;
            1: return {oper, 24'h000406};
            2: return sha[31:0];
            3: return {spa[15:0], sha[47:32]};
            4: return {MAC[15:0], spa[31:16]};
            5: return MAC[47:16];
            6: return LIP;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!sresetn) begin
            prev_tv = 1'b0;
            prev_rv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_tv && !prev_tr) chk("tx_hold", {bus.axis_o_tvalid, bus.axis_o_tdata}, {1'b1, prev_td});
            if (bus.axis_o_tvalid && !prev_tv && gap_pending) begin
                chk("retry_gap", cyc - last_cyc, TO + 1);
                gap_pending = 1'b0;
            end
            if (bus.axis_o_tvalid && bus.axis_o_tready) begin
                if (tx_q.size() == 0) chk("tx_extra", tx_q.size(), 1);
                else begin
                    tx_e = tx_q.pop_front();
                    chk("tx_beat", {bus.axis_o_tlast, bus.axis_o_tkeep, bus.axis_o_tdata}, tx_e);
                    if (bus.axis_o_tlast) begin
                        gap_pending = tx_q.size() > 0;
                        last_cyc = cyc;
                    end
                end
            end
            prev_tv = bus.axis_o_tvalid;
            prev_tr = bus.axis_o_tready;
            prev_td = bus.axis_o_tdata;
            if (prev_hs) chk("req_ready_after", bus.req_ready, 1);
            if (prev_rv && !prev_hs)
                chk("resp_hold", {bus.resp_valid, bus.resp_ok, bus.resp_ip, bus.resp_mac}, {1'b1, prev_resp});
            if (bus.resp_valid) chk("req_ready_busy", bus.req_ready, 0);
            if (bus.resp_valid && bus.resp_ready) begin
                if (resp_q.size() == 0) chk("resp_extra", resp_q.size(), 1);
                else begin
                    resp_e = resp_q.pop_front();
                    chk("resp", {bus.resp_ok, bus.resp_ip, bus.resp_mac}, resp_e);
                end
                resp_cnt++;
            end
            prev_rv = bus.resp_valid;
            prev_hs = bus.resp_valid && bus.resp_ready;
            prev_resp = {bus.resp_ok, bus.resp_ip, bus.resp_mac};
        end
    end

    task automatic do_req(input logic [31:0] ip, input bit ok, input logic [47:0] mac, input int attempts);
        int cnt = 0;
        for (int a = 0; a < attempts; a++)
            for (int i = 0; i < 7; i++) tx_q.push_back(tx_exp(i, ip));
        resp_q.push_back({ok, ip, mac});
        bus.req_ip = ip;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("req_accept", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int cnt = 0;
        while (tx_q.size() > n && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, tx_q.size(), n);
    endtask

    task automatic wait_resp(input int target, input string tag);
        int cnt = 0;
        while (resp_cnt < target && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, resp_cnt, target);
    endtask

    task automatic send_reply(input logic [7:0] oper, input logic [47:0] sha, input logic [31:0] spa, input int n, input bit exp_match);
        for (int i = 0; i < n; i++) begin
            bus.axis_i_tvalid = 1'b1;
            bus.axis_i_tdata = rx_word(i, oper, sha, spa);
            bus.axis_i_tlast = i == n - 1;
            @(posedge clk); #1;
            if (i == 6) chk("match_lat", bus.resp_valid, exp_match);
        end
        bus.axis_i_tvalid = 1'b0;
        bus.axis_i_tlast = 1'b0;
    endtask

    initial begin
        int n0;
        int cnt;
        bus.req_valid = 1'b0;
        bus.req_ip = '0;
        bus.resp_ready = 1'b1;
        bus.axis_i_tvalid = 1'b0;
        bus.axis_i_tlast = 1'b0;
        bus.axis_i_tkeep = 4'hF;
        bus.axis_i_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp", {bus.resp_valid, bus.resp_ok, bus.resp_ip, bus.resp_mac}, 0);
        chk("rst_tx", {bus.axis_o_tvalid, bus.axis_o_tlast, bus.axis_o_tkeep, bus.axis_o_tdata}, {2'b00, 4'hF, 32'h0});
        chk("rst_misc", {bus.axis_i_tready, bus.axis_o_dst_mac}, {1'b1, 48'hFFFF_FFFF_FFFF});
        sresetn = 1'b1;
        @(posedge clk); #1;
        // resolve
        do_req(IP_A, 1'b1, MAC_A, 1);
        wait_tx(0, "resolve_tx");
        send_reply(8'd2, MAC_A, IP_A, 7, 1'b1);
        wait_resp(1, "resolve_resp");
        // timeout after three identical requests
        do_req(IP_B, 1'b0, 48'h0, 3);
        wait_resp(2, "timeout_resp");
        // filtering: three non-matching packets, then a correct reply after the retry
        do_req(IP_A, 1'b1, MAC_A, 2);
        wait_tx(7, "filt_tx1");
        send_reply(8'd2, MAC_A, IP_BAD, 7, 1'b0);
        send_reply(8'd1, MAC_A, IP_A, 7, 1'b0);
        send_reply(8'd2, MAC_A, IP_A, 5, 1'b0);
        @(posedge clk); #1;
        chk("filt_none", resp_cnt, 2);
        wait_tx(0, "filt_tx2");
        send_reply(8'd2, MAC_A, IP_A, 7, 1'b1);
        wait_resp(3, "filt_resp");
        // backpressure on both output streams
        rnd = 1'b1;
        bus.resp_ready = 1'b0;
        do_req(IP_B, 1'b1, MAC_B, 1);
        wait_tx(0, "bp_tx");
        send_reply(8'd2, MAC_B, IP_B, 7, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_held", {bus.resp_valid, bus.req_ready}, 2'b10);
        bus.resp_ready = 1'b1;
        wait_resp(4, "bp_resp");
        rnd = 1'b0;
        // padded reply followed by a back-to-back request
        do_req(IP_A, 1'b1, MAC_C, 1);
        wait_tx(0, "pad_tx");
        send_reply(8'd2, MAC_C, IP_A, 12, 1'b1);
        wait_resp(5, "pad_resp");
        do_req(IP_B, 1'b1, MAC_B, 1);
        wait_tx(0, "b2b_tx");
        send_reply(8'd2, MAC_B, IP_B, 7, 1'b1);
        wait_resp(6, "b2b_resp");
        // reset in the middle of SEND
        n0 = resp_cnt;
        do_req(IP_A, 1'b1, MAC_A, 1);
        wait_tx(3, "rst_mid_tx");
        sresetn = 1'b0;
        tx_q.delete();
        resp_q.delete();
        #1;
        chk("rst_mid_tx_out", {bus.axis_o_tvalid, bus.axis_o_tlast, bus.axis_o_tkeep, bus.axis_o_tdata}, {2'b00, 4'hF, 32'h0});
        chk("rst_mid_ctl", {bus.req_ready, bus.resp_valid}, 2'b10);
        @(posedge clk); #1;
        sresetn = 1'b1;
        @(posedge clk); #1;
        do_req(IP_A, 1'b1, MAC_A, 1);
        wait_tx(0, "post_rst_tx");
        send_reply(8'd2, MAC_A, IP_A, 7, 1'b1);
        wait_resp(n0 + 1, "post_rst_resp");
        cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("tx_q_empty", tx_q.size(), cnt);
        chk("resp_q_empty", resp_q.size(), cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
